// File: rtl/vecmac_pkg.sv
// Shared definitions for the int8 dot-product sequencer: FSM states,
// partial-product shift table and nibble width.
package vecmac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } mac_state_t;

    localparam int unsigned NIB_W = 4;

    localparam int unsigned PP_SHIFT [0:3] = '{0, 4, 4, 8};

endpackage

// File: rtl/int8_mac_seq.sv
// Sequencer/accumulator for unsigned int8 dot products built from four 4x4
// nibble products per element. Optional saturation: define ACC_SAT_EN.
module int8_mac_seq
    import vecmac_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               a_in,
    input  logic [7:0]               b_in,
    input  logic                     last,
    output logic                     mul_start,
    output logic [NIB_W-1:0]         mul_a,
    output logic [NIB_W-1:0]         mul_b,
    input  logic [7:0]               mul_out,
    input  logic                     mul_finish,
    output logic [ACC_W-1:0]         acc_out,
    output logic [CNT_W-1:0]         acc_count,
    output logic                     acc_valid,
    input  logic                     acc_ready
`ifdef ACC_SAT_EN
    ,
    output logic                     acc_ovf
`endif
);

    mac_state_t state, state_next;

    logic [7:0]       a_q, b_q;
    logic             last_q;
    logic [1:0]       pp;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [NIB_W-1:0] nib_a, nib_b;
    logic [ACC_W-1:0] addend;
    logic [ACC_W-1:0] acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (mul_finish) begin
                         if (pp != 2'd3)  state_next = ISSUE;
                         else if (last_q) state_next = DONE;
                         else             state_next = IDLE;
                     end
            DONE:    if (acc_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        nib_a = '0;
        nib_b = '0;
        case (pp)
            2'd0: begin nib_a = a_q[3:0]; nib_b = b_q[3:0]; end
            2'd1: begin nib_a = a_q[3:0]; nib_b = b_q[7:4]; end
            2'd2: begin nib_a = a_q[7:4]; nib_b = b_q[3:0]; end
            default: begin nib_a = a_q[7:4]; nib_b = b_q[7:4]; end
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        mul_start = (state == ISSUE);
        acc_valid = (state == DONE);
        mul_a     = '0;
        mul_b     = '0;
        if (state == ISSUE || state == WAIT) begin
            mul_a = nib_a;
            mul_b = nib_b;
        end
    end

    assign addend = ACC_W'(mul_out) << PP_SHIFT[pp];

`ifdef ACC_SAT_EN
    logic [ACC_W:0] sum_ext;
    logic           ovf;

    // Addends are non-negative, so clamping each step equals clamping the total.
    always_comb begin
        sum_ext  = {1'b0, acc} + {1'b0, addend};
        acc_next = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (state == WAIT && mul_finish && sum_ext[ACC_W]) begin
            ovf <= 1'b1;
        end else if (state == DONE && acc_ready) begin
            ovf <= 1'b0;
        end
    end

    assign acc_ovf = ovf;
`else
    assign acc_next = acc + addend;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            last_q <= 1'b0;
            pp     <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q    <= a_in;
                    b_q    <= b_in;
                    last_q <= last;
                    pp     <= '0;
                end
                WAIT: if (mul_finish) begin
                    acc <= acc_next;
                    if (pp == 2'd3) cnt <= cnt + CNT_W'(1);
                    else            pp  <= pp + 2'd1;
                end
                DONE: if (acc_ready) begin
                    acc <= '0;
                    cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    assign acc_out   = acc;
    assign acc_count = cnt;

endmodule

// File: tb/tb_int8_mac_seq.sv
// Self-checking bench for int8_mac_seq with a behavioural 4x4 multiplier
// model (4-cycle busy) and an arithmetic dot-product reference.
module tb_int8_mac_seq;

    localparam int ACC_W = 16;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready;
    logic [7:0]       a_in, b_in;
    logic             last;
    logic             mul_start;
    logic [3:0]       mul_a, mul_b;
    logic [7:0]       mul_out;
    logic             mul_finish;
    logic [ACC_W-1:0] acc_out;
    logic [CNT_W-1:0] acc_count;
    logic             acc_valid, acc_ready;
`ifdef ACC_SAT_EN
    logic             acc_ovf;
    localparam bit    SAT = 1'b1;
`else
    localparam bit    SAT = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    int unsigned cyc = 0;
    int unsigned starts = 0;

    int8_mac_seq #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_in       (a_in),
        .b_in       (b_in),
        .last       (last),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_out    (mul_out),
        .mul_finish (mul_finish),
        .acc_out    (acc_out),
        .acc_count  (acc_count),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready)
`ifdef ACC_SAT_EN
        ,
        .acc_ovf    (acc_ovf)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mul_start) starts <= starts + 1;
    end

    // Multiplier stand-in: start at edge E, finish high in the 5th cycle after.
    logic [3:0] cap_a, cap_b;
    logic [2:0] m_cnt;
    logic       fin_r, stray;
    logic [7:0] prod;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0; fin_r <= 0; prod <= 0; cap_a <= 0; cap_b <= 0;
        end else begin
            fin_r <= 1'b0;
            if (mul_start) begin
                cap_a <= mul_a; cap_b <= mul_b; m_cnt <= 3'd4;
            end else if (m_cnt != 0) begin
                m_cnt <= m_cnt - 3'd1;
                if (m_cnt == 3'd1) begin
                    fin_r <= 1'b1;
                    prod  <= 8'(cap_a) * 8'(cap_b);
                end
            end
        end
    end

    assign mul_finish = fin_r | stray;
    assign mul_out    = stray ? 8'hAA : prod;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int unsigned ref_acc(input int unsigned total);
        int unsigned lim = (1 << ACC_W) - 1;
        if (SAT && total > lim) return lim;
        return total & lim;
    endfunction

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic l);
        int n;
        int unsigned t0, s0;
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        check("in_ready_before_send", in_ready, 1);
        a_in = a; b_in = b; last = l; in_valid = 1'b1;
        t0 = cyc; s0 = starts;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!in_ready && !acc_valid && n < 60) begin @(negedge clk); n++; end
        check("element_latency", cyc - t0, 25);
        check("mul_start_pulses", starts - s0, 4);
        check(l ? "acc_valid_after_last" : "in_ready_after_elem", l ? acc_valid : in_ready, 1);
    endtask

    task automatic collect(input int unsigned exp_acc, input int unsigned exp_cnt,
                           input bit exp_ovf, input int hold);
        int unsigned held;
        check("acc_valid", acc_valid, 1);
        check("acc_out", acc_out, exp_acc);
        check("acc_count", acc_count, exp_cnt);
`ifdef ACC_SAT_EN
        check("acc_ovf", acc_ovf, exp_ovf);
`endif
        held = acc_out;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_acc_valid", acc_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_acc_out_stable", acc_out, held);
        end
        acc_ready = 1'b1;
        @(negedge clk);
        acc_ready = 1'b0;
        check("post_hs_in_ready", in_ready, 1);
        check("post_hs_acc_valid", acc_valid, 0);
        check("post_hs_acc_out", acc_out, 0);
        check("post_hs_acc_count", acc_count, 0);
`ifdef ACC_SAT_EN
        check("post_hs_acc_ovf", acc_ovf, 0);
`else
        if (exp_ovf) check("no_ovf_expected", 1, 0);
`endif
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        l;
        int unsigned exp_acc;
        int unsigned exp_cnt;
        bit          exp_ovf;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned total, len, pa, pb;
        vecs[0] = '{8'hFF, 8'hFF, 1'b1, 32'hFE01, 1, 1'b0};
        vecs[1] = '{8'h12, 8'h34, 1'b0, 0, 0, 1'b0};
        vecs[2] = '{8'hAB, 8'hCD, 1'b0, 0, 0, 1'b0};
        vecs[3] = '{8'h80, 8'h02, 1'b1, 32'h8D97, 3, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 1'b0, 0, 0, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, SAT ? 32'hFFFF : 32'hFC02, 2, SAT};
        vecs[6] = '{8'h03, 8'h05, 1'b1, 15, 1, 1'b0};

        rst_n = 1'b0; in_valid = 0; a_in = 0; b_in = 0; last = 0;
        acc_ready = 0; stray = 0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_mul_start", mul_start, 0);
        check("rst_mul_ab", {mul_a, mul_b}, 0);
        check("rst_acc_out", acc_out, 0);
        check("rst_acc_count", acc_count, 0);
        check("rst_acc_valid", acc_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].l);
            if (vecs[i].l)
                collect(vecs[i].exp_acc, vecs[i].exp_cnt, vecs[i].exp_ovf, (i == 0) ? 10 : 0);
        end

        // Stray finish while idle, then an all-zero-product element.
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        check("stray_acc_out", acc_out, 0);
        check("stray_in_ready", in_ready, 1);
        send(8'h00, 8'h7F, 1'b1);
        collect(0, 1, 1'b0, 0);

        // Reset during the WAIT of partial 2.
        a_in = 8'h55; b_in = 8'h66; last = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (14) @(negedge clk);
        check("pre_rst_in_wait", in_ready | acc_valid | mul_start, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_mul_start", mul_start, 0);
        check("midrst_mul_ab", {mul_a, mul_b}, 0);
        check("midrst_acc_out", acc_out, 0);
        check("midrst_acc_count", acc_count, 0);
        check("midrst_acc_valid", acc_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'd3, 8'd5, 1'b1);
        collect(15, 1, 1'b0, 0);

        // Random vectors against the arithmetic reference.
        for (int v = 0; v < 20; v++) begin
            len = $urandom_range(1, 4);
            total = 0;
            for (int unsigned e = 0; e < len; e++) begin
                pa = $urandom_range(0, 255);
                pb = $urandom_range(0, 255);
                total += pa * pb;
                if (e == len - 1 && (v % 3) == 0) acc_ready = 1'b1;
                send(pa[7:0], pb[7:0], e == len - 1);
            end
            collect(ref_acc(total), len, SAT && (total > (1 << ACC_W) - 1), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/int8_mac_seq.md
# int8_mac_seq

Sequencer and accumulator for unsigned int8 dot products. It feeds the 4x4 shift-and-add nibble multiplier and consumes its results. Each accepted int8 operand pair is split into four nibble-pair products, issued one at a time to the multiplier. The returned 8-bit products are shifted and summed into a running accumulator, which is presented on a valid/ready output when the element flagged `last` has been absorbed.

## Interface
- `ACC_W`, 24: accumulator and result width; must be ≥16.
- `CNT_W`, 8: width of the element counter.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset. The multiplier's active-high `rst` is driven by `~rst_n` at the parent level.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: sequencer can accept an operand pair.
- `a_in`, `b_in` in 8: unsigned operands.
- `last` in 1: this pair closes the current dot product.
- `mul_start` out 1: one-cycle start pulse to the multiplier.
- `mul_a`, `mul_b` out 4: nibble operands to the multiplier.
- `mul_out` in 8: multiplier product.
- `mul_finish` in 1: multiplier done pulse, one cycle.
- `acc_out` out `ACC_W`: dot-product result.
- `acc_count` out `CNT_W`: number of elements summed into `acc_out`; wraps modulo 2^`CNT_W`.
- `acc_valid` out 1: result valid.
- `acc_ready` in 1: consumer takes the result.
- `acc_ovf` out 1: accumulation overflowed. Present only with `ACC_SAT_EN`.

## Operation
- **States:** IDLE, ISSUE, WAIT, DONE. The reset state is IDLE.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid`, latch `a_in`, `b_in`, `last`; set partial index `pp`=0; go to ISSUE.
- **ISSUE:**
  - `mul_start`=1 for exactly one cycle.
  - `mul_a`/`mul_b` are selected by `pp`:
    - `pp`=0: aL·bL, shift 0.
    - `pp`=1: aL·bH, shift 4.
    - `pp`=2: aH·bL, shift 4.
    - `pp`=3: aH·bH, shift 8.
  - Then go to WAIT.
- **WAIT:**
  - `mul_a`/`mul_b` are held stable.
  - On `mul_finish`, add `mul_out` zero-extended and left-shifted by the table shift into the accumulator.
  - If `pp`<3: increment `pp`, go to ISSUE.
  - If `pp`=3: increment the element counter. Go to DONE if the latched `last`=1, else go to IDLE.
- **DONE:**
  - `acc_valid`=1; `acc_out` and `acc_count` are held stable.
  - On `acc_ready`: clear the accumulator and counter, go to IDLE.
- **Ignored inputs:** `mul_finish` outside WAIT is ignored. `in_valid` outside IDLE is not accepted.
- **Arithmetic:** all unsigned. Without saturation the sum wraps modulo 2^`ACC_W`.
- **Zero operands** still run all four partials; there is no early-out.
- **Reset mid-operation:** return to IDLE, clear accumulator, counter and flags, drop any in-flight partial. The multiplier is reset by the same net.
- **Reset values:**
  - `mul_start`=0, `mul_a`=`mul_b`=0, `acc_out`=0, `acc_count`=0, `acc_valid`=0, `acc_ovf`=0.
  - `in_ready`=1, since it is decoded from IDLE.

## Timing
- Accept cycle T0. Partial k has ISSUE in T(1+6k). The multiplier is busy for four cycles and `mul_finish` is sampled in T(6+6k).
- The last partial's finish lands in T24. The next `in_ready` or `acc_valid` is high in T25.
- Throughput is one element per 25 cycles. Back-to-back elements are accepted in consecutive IDLE cycles with no bubble beyond IDLE itself.
- `acc_valid` holds indefinitely under `acc_ready`=0, and `in_ready` stays 0 for that time.
- If `acc_ready` is already high when DONE is entered, the handshake completes in that same cycle.

## Configuration
- **`ACC_SAT_EN` defined:**
  - A sum exceeding 2^`ACC_W`−1 clamps `acc_out` to all-ones and sets sticky `acc_ovf`.
  - `acc_ovf` clears on the DONE handshake or on reset.
- **`ACC_SAT_EN` undefined:**
  - The sum wraps.
  - The `acc_ovf` port and its logic are absent.

## Structure
- **Shared package `vecmac_pkg`:**
  - state enum `mac_state_t`.
  - partial-product shift constants `PP_SHIFT[0:3]` = {0,4,4,8}.
  - nibble width constant `NIB_W`=4.
- **No sub-module.** The nibble multiplier is instantiated beside this block at the parent level, not inside it.

## Test plan
- **Single element:** a=0xFF, b=0xFF, last=1 → `acc_valid` in T25, `acc_out`=0xFE01, `acc_count`=1, exactly four `mul_start` pulses.
- **Three-element vector:** pairs (0x12,0x34), (0xAB,0xCD), (0x80,0x02) with last on the third → `acc_out`=0x8D97, `acc_count`=3.
- **Backpressure:** hold `acc_ready`=0 for 10 cycles after `acc_valid` → `acc_out` stable, `in_ready`=0 throughout. After release, the accumulator reads 0 for the next vector.
- **Reset mid-WAIT:** deassert `rst_n` during partial 2 → all outputs at reset values immediately. A fresh pair (3,5,last) then yields `acc_out`=15.
- **Overflow, `ACC_W`=16:** two pairs (0xFF,0xFF), last on the second → with `ACC_SAT_EN`: `acc_out`=0xFFFF, `acc_ovf`=1. Without it: `acc_out`=0xFC02.
- **Zero and stray finish:** pair (0x00,0x7F), last=1, with a stray `mul_finish` injected in IDLE → the stray pulse is ignored, `acc_out`=0, result in T25.
